// File: rtl/ap_pkg.sv
// Shared definitions for the associative-processor host sequencer:
// operation/column/error codes, state encoding and default geometry.
package ap_pkg;

  function automatic int clogb2(input int value);
    int n;
    n = 0;
    for (int v = value; v > 0; v = v >> 1) n++;
    return n;
  endfunction

  localparam int AP_WORD_SIZE   = 8;
  localparam int AP_CELL_QUANT  = 512;
  localparam int AP_ADDR_W      = clogb2(AP_CELL_QUANT);
  localparam int AP_RD_LAT      = 2;
  localparam int AP_RUN_TIMEOUT = 255;

  localparam logic [2:0] AP_OR  = 3'd0;
  localparam logic [2:0] AP_XOR = 3'd1;
  localparam logic [2:0] AP_AND = 3'd2;
  localparam logic [2:0] AP_NOT = 3'd3;

  localparam logic [1:0] COL_A = 2'd0;
  localparam logic [1:0] COL_B = 2'd1;
  localparam logic [1:0] COL_C = 2'd2;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_CMD = 2'd1;
  localparam logic [1:0] ERR_BAD_N   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_LD_WAIT,
    S_WR_A,
    S_WR_B,
    S_WR_GAP,
    S_RUN,
    S_RD_ISSUE,
    S_RD_HOLD,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/ap_host_seq_if.sv
// Job request, operand/result streams, status and the AP register-style host port.
// The sequencer drives through the master modport; the system/AP side uses slave.
interface ap_host_seq_if
  import ap_pkg::*;
#(
  parameter int WORD_SIZE = AP_WORD_SIZE,
  parameter int ADDR_W    = AP_ADDR_W
) ();

  logic                   start;
  logic [2:0]             cmd;
  logic [ADDR_W-1:0]      n_cells;
  logic                   ld_valid;
  logic                   ld_ready;
  logic [2*WORD_SIZE-1:0] ld_data;
  logic                   res_valid;
  logic                   res_ready;
  logic [WORD_SIZE-1:0]   res_data;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [1:0]             err_code;

  logic                   ap_rst;
  logic                   ap_mode;
  logic [2:0]             ap_cmd;
  logic [ADDR_W-1:0]      ap_addr;
  logic [WORD_SIZE-1:0]   ap_data_in;
  logic [1:0]             ap_sel_col;
  logic                   ap_sel_internal_col;
  logic                   ap_write_en;
  logic                   ap_read_en;
  logic [WORD_SIZE-1:0]   ap_data_out;
  logic                   ap_state_irq;

  modport master (
    input  start, cmd, n_cells, ld_valid, ld_data, res_ready, ap_data_out, ap_state_irq,
    output ld_ready, res_valid, res_data, busy, done, err, err_code,
           ap_rst, ap_mode, ap_cmd, ap_addr, ap_data_in, ap_sel_col,
           ap_sel_internal_col, ap_write_en, ap_read_en
  );

  modport slave (
    output start, cmd, n_cells, ld_valid, ld_data, res_ready, ap_data_out, ap_state_irq,
    input  ld_ready, res_valid, res_data, busy, done, err, err_code,
           ap_rst, ap_mode, ap_cmd, ap_addr, ap_data_in, ap_sel_col,
           ap_sel_internal_col, ap_write_en, ap_read_en
  );

endinterface

// File: rtl/ap_host_seq.sv
// Host-side job sequencer: clear AP, load A/B columns, run the op, stream column C out.
//   state      | meaning
//   IDLE       | wait for start, validate job
//   CLR        | ap_rst high for 2 cycles
//   LD_WAIT    | ld_ready high, wait for operand pair
//   WR_A       | write A to column A, 2 cycles
//   WR_B       | write B to column B, 2 cycles
//   WR_GAP     | 1 idle cycle, next cell or RUN
//   RUN        | ap_mode high, wait for irq or timeout
//   RD_ISSUE   | read column C, RD_LAT+1 cycles
//   RD_HOLD    | res_valid high until res_ready
//   DONE       | done pulse
//   ERR        | err set, ap_rst pulse
module ap_host_seq
  import ap_pkg::*;
#(
  parameter int WORD_SIZE   = AP_WORD_SIZE,
  parameter int CELL_QUANT  = AP_CELL_QUANT,
  parameter int ADDR_W      = clogb2(CELL_QUANT),
  parameter int RD_LAT      = AP_RD_LAT,
  parameter int RUN_TIMEOUT = AP_RUN_TIMEOUT
) (
  input  logic          CLK100MHZ,
  input  logic          rst_n,
  ap_host_seq_if.master bus
);

  localparam int HOLD_W = (clogb2(RD_LAT) > 1) ? clogb2(RD_LAT) : 1;
  localparam int RUN_W  = (clogb2(RUN_TIMEOUT) > 1) ? clogb2(RUN_TIMEOUT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_TWO = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_RD  = HOLD_W'(RD_LAT);
  localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(RUN_TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [ADDR_W-1:0]      idx_q, idx_d;
  logic [RUN_W-1:0]       run_q, run_d;
  logic [2:0]             cmd_q, cmd_d;
  logic [ADDR_W-1:0]      n_q, n_d;
  logic [WORD_SIZE-1:0]   a_q, a_d, b_q, b_d;
  logic [WORD_SIZE-1:0]   res_data_q, res_data_d;
  logic                   err_q, err_d;
  logic [1:0]             err_code_q, err_code_d;

  logic                   ld_ready_q, ld_ready_d;
  logic                   res_valid_q, res_valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ap_rst_q, ap_rst_d;
  logic                   ap_mode_q, ap_mode_d;
  logic [2:0]             ap_cmd_q, ap_cmd_d;
  logic [ADDR_W-1:0]      ap_addr_q, ap_addr_d;
  logic [WORD_SIZE-1:0]   ap_data_in_q, ap_data_in_d;
  logic [1:0]             ap_sel_col_q, ap_sel_col_d;
  logic                   ap_write_en_q, ap_write_en_d;
  logic                   ap_read_en_q, ap_read_en_d;

  logic cmd_ok, n_bad, last_cell;

  assign cmd_ok    = bus.cmd inside {AP_OR, AP_XOR, AP_AND, AP_NOT};
  assign n_bad     = (bus.n_cells == '0) ||
                     ({1'b0, bus.n_cells} > (ADDR_W + 1)'(CELL_QUANT));
  assign last_cell = (idx_q == n_q - ADDR_W'(1));

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    idx_d      = idx_q;
    run_d      = run_q;
    cmd_d      = cmd_q;
    n_d        = n_q;
    a_d        = a_q;
    b_d        = b_q;
    res_data_d = res_data_q;
    err_d      = err_q;
    err_code_d = err_code_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cmd_d = bus.cmd;
          n_d   = bus.n_cells;
          idx_d = '0;
          run_d = '0;
          if (!cmd_ok) begin
            state_d    = S_ERR;
            err_code_d = ERR_BAD_CMD;
          end else if (n_bad) begin
            state_d    = S_ERR;
            err_code_d = ERR_BAD_N;
          end else begin
            state_d    = S_CLR;
            hold_d     = HOLD_TWO;
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
          end
        end
      end
      S_CLR: begin
        idx_d = '0;
        if (hold_q == '0) state_d = S_LD_WAIT;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      S_LD_WAIT: begin
        if (bus.ld_valid && ld_ready_q) begin
          a_d     = bus.ld_data[WORD_SIZE-1:0];
          b_d     = bus.ld_data[2*WORD_SIZE-1:WORD_SIZE];
          state_d = S_WR_A;
          hold_d  = HOLD_TWO;
        end
      end
      S_WR_A: begin
        if (hold_q == '0) begin
          state_d = S_WR_B;
          hold_d  = HOLD_TWO;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      S_WR_B: begin
        if (hold_q == '0) state_d = S_WR_GAP;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      S_WR_GAP: begin
        if (last_cell) begin
          state_d = S_RUN;
          idx_d   = '0;
          run_d   = '0;
        end else begin
          state_d = S_LD_WAIT;
          idx_d   = idx_q + ADDR_W'(1);
        end
      end
      S_RUN: begin
        // irq wins over a timeout hitting in the same cycle
        if (bus.ap_state_irq) begin
          state_d = S_RD_ISSUE;
          hold_d  = HOLD_RD;
        end else if (run_q == RUN_LAST) begin
          state_d    = S_ERR;
          err_code_d = ERR_TIMEOUT;
        end else begin
          run_d = run_q + RUN_W'(1);
        end
      end
      S_RD_ISSUE: begin
        if (hold_q == '0) begin
          res_data_d = bus.ap_data_out;
          state_d    = S_RD_HOLD;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      S_RD_HOLD: begin
        if (bus.res_ready) begin
          if (last_cell) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD_ISSUE;
            hold_d  = HOLD_RD;
            idx_d   = idx_q + ADDR_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ERR) err_d = 1'b1;
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    ld_ready_d    = (state_d == S_LD_WAIT);
    res_valid_d   = (state_d == S_RD_HOLD);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    ap_rst_d      = (state_d == S_CLR) || (state_d == S_ERR);
    ap_mode_d     = 1'b0;
    ap_cmd_d      = '0;
    ap_addr_d     = '0;
    ap_data_in_d  = '0;
    ap_sel_col_d  = '0;
    ap_write_en_d = 1'b0;
    ap_read_en_d  = 1'b0;
    case (state_d)
      S_WR_A: begin
        ap_addr_d     = idx_d;
        ap_sel_col_d  = COL_A;
        ap_data_in_d  = a_d;
        ap_write_en_d = 1'b1;
      end
      S_WR_B: begin
        ap_addr_d     = idx_d;
        ap_sel_col_d  = COL_B;
        ap_data_in_d  = b_d;
        ap_write_en_d = 1'b1;
      end
      S_RUN: begin
        ap_mode_d = 1'b1;
        ap_cmd_d  = cmd_d;
      end
      S_RD_ISSUE: begin
        ap_addr_d    = idx_d;
        ap_sel_col_d = COL_C;
        ap_read_en_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      hold_q        <= '0;
      idx_q         <= '0;
      run_q         <= '0;
      cmd_q         <= '0;
      n_q           <= '0;
      a_q           <= '0;
      b_q           <= '0;
      res_data_q    <= '0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
      ld_ready_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ap_rst_q      <= 1'b0;
      ap_mode_q     <= 1'b0;
      ap_cmd_q      <= '0;
      ap_addr_q     <= '0;
      ap_data_in_q  <= '0;
      ap_sel_col_q  <= '0;
      ap_write_en_q <= 1'b0;
      ap_read_en_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      idx_q         <= idx_d;
      run_q         <= run_d;
      cmd_q         <= cmd_d;
      n_q           <= n_d;
      a_q           <= a_d;
      b_q           <= b_d;
      res_data_q    <= res_data_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      ld_ready_q    <= ld_ready_d;
      res_valid_q   <= res_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      ap_rst_q      <= ap_rst_d;
      ap_mode_q     <= ap_mode_d;
      ap_cmd_q      <= ap_cmd_d;
      ap_addr_q     <= ap_addr_d;
      ap_data_in_q  <= ap_data_in_d;
      ap_sel_col_q  <= ap_sel_col_d;
      ap_write_en_q <= ap_write_en_d;
      ap_read_en_q  <= ap_read_en_d;
    end
  end

  assign bus.ld_ready            = ld_ready_q;
  assign bus.res_valid           = res_valid_q;
  assign bus.res_data            = res_data_q;
  assign bus.busy                = busy_q;
  assign bus.done                = done_q;
  assign bus.err                 = err_q;
  assign bus.err_code            = err_code_q;
  assign bus.ap_rst              = ap_rst_q;
  assign bus.ap_mode             = ap_mode_q;
  assign bus.ap_cmd              = ap_cmd_q;
  assign bus.ap_addr             = ap_addr_q;
  assign bus.ap_data_in          = ap_data_in_q;
  assign bus.ap_sel_col          = ap_sel_col_q;
  assign bus.ap_sel_internal_col = 1'b0;
  assign bus.ap_write_en         = ap_write_en_q;
  assign bus.ap_read_en          = ap_read_en_q;

endmodule

// File: tb/tb_ap_host_seq.sv
// Directed bench for ap_host_seq with a behavioural three-column AP behind the host port.
module tb_ap_host_seq;
  import ap_pkg::*;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [9:0]  n;
    logic [31:0] a;    // cell i in byte i
    logic [31:0] b;
    logic [31:0] res;
    logic        stall;
  } vec_t;

  localparam int NV = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks, n_pass;
  int   wr_cnt = 0, rst_cnt = 0, mode_cnt = 0;
  bit   irq_en;
  int   irq_lat;
  vec_t vecs[NV];

  ap_host_seq_if bus ();

  ap_host_seq dut (
    .CLK100MHZ(clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Behavioural AP: column memories, irq after irq_lat+1 mode cycles, 2-cycle read pipe.
  logic [7:0] mem_a[512];
  logic [7:0] mem_b[512];
  logic [7:0] mem_c[512];
  logic [7:0] rd1 = 8'h00, dout = 8'h00;
  logic       irq = 1'b0;
  int         mcnt = 0;

  always @(posedge clk) begin
    if (bus.ap_write_en) begin
      if (bus.ap_sel_col == COL_A) mem_a[bus.ap_addr[8:0]] <= bus.ap_data_in;
      if (bus.ap_sel_col == COL_B) mem_b[bus.ap_addr[8:0]] <= bus.ap_data_in;
    end
    if (!bus.ap_mode) begin
      mcnt <= 0;
      irq  <= 1'b0;
    end else if (mcnt == irq_lat) begin
      irq <= irq_en;
      for (int i = 0; i < 512; i++) begin
        case (bus.ap_cmd)
          AP_OR:   mem_c[i] <= mem_a[i] | mem_b[i];
          AP_XOR:  mem_c[i] <= mem_a[i] ^ mem_b[i];
          AP_AND:  mem_c[i] <= mem_a[i] & mem_b[i];
          default: mem_c[i] <= ~mem_a[i];
        endcase
      end
    end else begin
      mcnt <= mcnt + 1;
    end
    rd1  <= (bus.ap_read_en && bus.ap_sel_col == COL_C) ? mem_c[bus.ap_addr[8:0]] : 8'h00;
    dout <= rd1;
    if (bus.ap_write_en) wr_cnt <= wr_cnt + 1;
    if (bus.ap_rst)      rst_cnt <= rst_cnt + 1;
    if (bus.ap_mode)     mode_cnt <= mode_cnt + 1;
  end

  assign bus.ap_data_out  = dout;
  assign bus.ap_state_irq = irq;

  function automatic logic [63:0] outs();
    return {21'b0, bus.ld_ready, bus.res_valid, bus.res_data, bus.busy, bus.done,
            bus.err, bus.err_code, bus.ap_rst, bus.ap_mode, bus.ap_cmd, bus.ap_addr,
            bus.ap_data_in, bus.ap_sel_col, bus.ap_sel_internal_col, bus.ap_write_en,
            bus.ap_read_en};
  endfunction

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic start_job(input logic [2:0] cmd, input logic [9:0] n);
    bus.start   = 1'b1;
    bus.cmd     = cmd;
    bus.n_cells = n;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic load_pair(input string name, input logic [7:0] a, input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_data  = {b, a};
    for (int k = 0; k < 50 && !ok; k++) begin
      if (bus.ld_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.ld_valid = 1'b0;
    check_eq({name, ".ld_handshake"}, 64'(ok), 64'd1);
  endtask

  task automatic do_job(input string name, input logic [2:0] cmd, input logic [9:0] n,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                        input bit stall);
    int         wr_base, rst_base, got;
    bit         have_prev, rdy;
    logic [7:0] prev;
    wr_base   = wr_cnt;
    rst_base  = rst_cnt;
    got       = 0;
    have_prev = 1'b0;
    prev      = 8'h00;
    start_job(cmd, n);
    check_eq({name, ".busy_err"}, 64'({bus.busy, bus.err}), 64'b10);
    for (int i = 0; i < int'(n); i++) load_pair(name, a[8*i +: 8], b[8*i +: 8]);
    for (int k = 0; k < 800 && got < int'(n); k++) begin
      rdy = stall ? (((k / 3) % 2) == 1) : 1'b1;
      bus.res_ready = rdy;
      if (bus.res_valid) begin
        if (have_prev) check_eq({name, ".res_stable"}, 64'(bus.res_data), 64'(prev));
        if (rdy) begin
          check_eq($sformatf("%s.res[%0d]", name, got), 64'(bus.res_data), 64'(res[8*got +: 8]));
          got++;
          have_prev = 1'b0;
        end else begin
          prev      = bus.res_data;
          have_prev = 1'b1;
        end
      end else if (have_prev) begin
        check_eq({name, ".res_valid_held"}, 64'(bus.res_valid), 64'd1);
        have_prev = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b0;
    check_eq({name, ".res_count"}, 64'(got), 64'(n));
    check_eq({name, ".done"}, 64'({bus.done, bus.busy}), 64'b11);
    @(posedge clk); #1;
    check_eq({name, ".idle"}, 64'({bus.done, bus.busy, bus.res_valid, bus.err}), 64'd0);
    check_eq({name, ".wr_cycles"}, 64'(wr_cnt - wr_base), 64'(4 * int'(n)));
    check_eq({name, ".clr_cycles"}, 64'(rst_cnt - rst_base), 64'd2);
  endtask

  task automatic bad_job(input string name, input logic [2:0] cmd, input logic [9:0] n,
                         input logic [1:0] code);
    int wr_base;
    wr_base = wr_cnt;
    start_job(cmd, n);
    check_eq({name, ".err"}, 64'({bus.err, bus.err_code, bus.busy, bus.ap_rst}),
             64'({1'b1, code, 2'b11}));
    @(posedge clk); #1;
    check_eq({name, ".idle"}, 64'({bus.busy, bus.err, bus.err_code, bus.ap_rst}),
             64'({2'b01, code, 1'b0}));
    check_eq({name, ".no_writes"}, 64'(wr_cnt - wr_base), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  mode_base;
    bit  found, quiet;
    n_checks = 0;
    n_pass   = 0;
    irq_en   = 1'b1;
    irq_lat  = 8;
    bus.start = 1'b0; bus.cmd = '0; bus.n_cells = '0;
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.res_ready = 1'b0;

    //            cmd     n      A (cell3..0)   B (cell3..0)   C expected     stall
    vecs[0] = '{AP_XOR, 10'd4, 32'hFF00AA0F, 32'hFF0055FF, 32'h0000FFF0, 1'b0};
    vecs[1] = '{AP_NOT, 10'd2, 32'h0000003C, 32'h00005A77, 32'h0000FFC3, 1'b0};
    vecs[2] = '{AP_AND, 10'd4, 32'h81FF3CF0, 32'hC3000FFF, 32'h81000CF0, 1'b1};
    vecs[3] = '{AP_OR,  10'd3, 32'h00F00081, 32'h000F0018, 32'h00FF0099, 1'b0};
    vecs[4] = '{AP_XOR, 10'd1, 32'h0000005A, 32'h000000A5, 32'h000000FF, 1'b1};

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_eq("reset.outs_async", outs(), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("reset.outs_idle", outs(), 64'd0);

    bad_job("bad_cmd", 3'd5, 10'd1, ERR_BAD_CMD);
    bad_job("zero_cells", AP_OR, 10'd0, ERR_BAD_N);
    bad_job("too_many_cells", AP_OR, 10'd513, ERR_BAD_N);

    for (int i = 0; i < NV; i++)
      do_job($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].n, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].stall);

    // irq lands in the last RUN cycle before the timeout: must count as success
    irq_lat = 253;
    do_job("irq_at_limit", AP_XOR, 10'd1, 32'h3C, 32'h0F, 32'h33, 1'b0);
    irq_lat = 8;

    irq_en    = 1'b0;
    mode_base = mode_cnt;
    found     = 1'b0;
    start_job(AP_AND, 10'd1);
    load_pair("timeout", 8'h11, 8'h22);
    for (int k = 0; k < 400 && !found; k++) begin
      if (bus.err) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check_eq("timeout.seen", 64'(found), 64'd1);
    check_eq("timeout.err", 64'({bus.err, bus.err_code, bus.ap_mode, bus.busy, bus.ap_rst}),
             64'({1'b1, ERR_TIMEOUT, 3'b011}));
    check_eq("timeout.run_cycles", 64'(mode_cnt - mode_base), 64'd255);
    @(posedge clk); #1;
    check_eq("timeout.idle", 64'({bus.busy, bus.err, bus.err_code}), 64'({2'b01, ERR_TIMEOUT}));
    irq_en = 1'b1;

    start_job(AP_OR, 10'd4);
    load_pair("midrst", 8'h01, 8'h10);
    load_pair("midrst", 8'h02, 8'h20);
    load_pair("midrst", 8'h03, 8'h30);
    check_eq("midrst.writing", 64'(bus.ap_write_en), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_eq("midrst.outs_async", outs(), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    quiet = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.done || bus.err || bus.busy || bus.ap_write_en) quiet = 1'b0;
    end
    check_eq("midrst.quiet", 64'(quiet), 64'd1);
    do_job("fresh_or", AP_OR, 10'd1, 32'h81, 32'h18, 32'h99, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
